mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter and sequencer that shares one 4×4 shift-add multiplier (init/done handshake, 8-bit product) between two requesters. It sits between the two consumers and the multiplier instance. It latches the granted operands, issues a one-cycle start, and detects completion on the rising edge of the multiplier's level `done`. It returns the product to the owning port and recovers from a hung multiplier with a timeout.

## Interface
- `TIMEOUT`, default 31: maximum cycles in WAIT before the transaction is aborted; range 4..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, reset asynchronous and active-low.
- `req0`, `req1`  in  1  request level; operands must be stable while high.
- `md0`, `mr0`, `md1`, `mr1`  in  4 each  multiplicand and multiplier per port.
- `rsp_valid0`, `rsp_valid1`  out  1  one-cycle completion pulse to the owning port.
- `err0`, `err1`  out  1  one-cycle pulse, coincident with `rsp_valid`, on timeout.
- `res0`, `res1`  out  8  last product delivered to that port; held until overwritten.
- `mul_init`  out  1  one-cycle start to the multiplier.
- `mul_md`, `mul_mr`  out  4 each  latched operands; stable from ISSUE until the next grant.
- `mul_done`  in  1  multiplier done level; may stay high until the next init.
- `mul_pp`  in  8  multiplier product.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  port currently or last granted.

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER. Encoding comes from the package.
- IDLE: sample `req0`/`req1`. If neither is set, stay. If one is set, grant it. If both are set, grant the port that is not `last_owner`. On grant, latch that port's operands into `mul_md`/`mul_mr`, set `owner`, and go to ISSUE.
- ISSUE: `mul_init`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: register `done_q` <= `mul_done` every cycle. Completion is `mul_done & ~done_q`. A level that is already high from the previous operation never completes a transaction.
  - On completion: capture `mul_pp` into `res[owner]` and go to DELIVER.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to DELIVER with the abort flag set.
- DELIVER: pulse `rsp_valid[owner]`, plus `err[owner]` if the transaction was aborted; `res` is unchanged on abort. Set `last_owner`=`owner`. Go to IDLE.
- A requester that still holds `req` high in the cycle after `rsp_valid` starts a new transaction with its current operands. Because of round-robin, the other port wins if it is also requesting.
- `req` falling mid-transaction is ignored; the transaction completes and the result is delivered anyway.
- Reset values: state IDLE, `mul_init`=0, `mul_md`=`mul_mr`=0, `res0`=`res1`=0, all `rsp_valid`/`err`=0, `busy`=0, `owner`=0, `last_owner`=1 (port 0 wins the first tie), `done_q`=0, counter 0.
- Reset mid-transaction: return to IDLE immediately with no response pulse. The multiplier is reset on the same net.

## Timing
- All outputs are registered.
- Request seen in IDLE at cycle t:
  - ISSUE at t+1 (`mul_init` high, operands valid).
  - WAIT from t+2.
  - Completion edge detected at cycle c gives DELIVER and `rsp_valid` at c+1, with `res` valid the same cycle.
- Minimum turnaround is 4 cycles plus the multiplier latency.
- Timeout: `rsp_valid`+`err` at t+2+`TIMEOUT`+1.
- Back-to-back: IDLE lasts exactly one cycle between transactions.

## Structure
- Package `mult_ctrl_pkg`: state localparams and the port-index constants.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from `req0`, `req1` and `last_owner`, producing `grant_valid` and `grant_id`.
- Everything else lives in `mult_arbiter`.

## Test plan
- **Single request.** After reset, `req0`=1, `md0`=3, `mr0`=5. Behavioral multiplier model asserts `done` 8 cycles after init with `pp`=15.
  - `mul_init` one pulse at t+1.
  - `rsp_valid0` pulse with `res0`=8'h0F.
  - `rsp_valid1`/`err0` never high.
- **Tie after reset.** `req0`=`req1`=1 in the same cycle (0: 2×7, 1: 4×4).
  - Port 0 is served first (`res0`=14), then port 1 (`res1`=16).
  - Then hold both `req` high: grants alternate 0,1,0,1.
- **Stale done.** The model keeps `done` high after an operation until the next init and clears it one cycle after init.
  - The second transaction waits for the new rising edge.
  - No early `rsp_valid`.
- **Timeout.** The model never raises `done` with `TIMEOUT`=31.
  - `rsp_valid1`+`err1` pulse 34 cycles after the request is sampled.
  - `res1` unchanged.
  - Returns to IDLE, and the next request is served normally.
- **Reset mid-WAIT.** Assert `rst` low during WAIT.
  - All outputs reach reset values asynchronously.
  - No response pulse.
  - After release, `owner`=0 and a pending tie is granted to port 0.
- **Request dropped mid-op.** `req0` is deasserted in WAIT.
  - `rsp_valid0` and `res0` are still delivered.
  - No new transaction starts for port 0.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_ctrl_pkg
// Shared definitions for the multiplier arbiter/sequencer:
//   - FSM state encoding (IDLE, ISSUE, WAIT, DELIVER)
//   - requester port indices
//   - operand/product/counter widths
//   - debug struct that exposes the sequencer's internal state
//   - small operand-select helper
// -----------------------------------------------------------------------------
package mult_ctrl_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  // Requester port indices
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Datapath widths
  localparam int OP_W  = 4;
  localparam int PP_W  = 8;
  // Wide enough for the largest supported timeout (255)
  localparam int CNT_W = 8;

  // Internal state made visible for checkers and debug
  typedef struct packed {
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             last_owner;
  } mult_dbg_t;

  // Select the operand belonging to the granted port
  function automatic logic [OP_W-1:0] pick_op(input logic            sel,
                                              input logic [OP_W-1:0] op0,
                                              input logic [OP_W-1:0] op1);
    return (sel == PORT1) ? op1 : op0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   req0, req1   : request levels from the two ports
//   last_owner   : port served most recently
//   grant_valid  : at least one port is requesting
//   grant_id     : chosen port; on a tie the port that was not served last
// -----------------------------------------------------------------------------
module rr_arbiter2
  import mult_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 & req1) begin
      grant_id = ~last_owner;
    end else if (req1) begin
      grant_id = PORT1;
    end else begin
      grant_id = PORT0;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one 4x4 shift-add multiplier between two requesters. Arbitrates
// round-robin, latches the winner's operands, issues a one-cycle init,
// waits for a rising edge of the multiplier's done level (or a timeout),
// then returns the product to the owning port.
//
// Parameters
//   TIMEOUT      : max cycles spent in WAIT before aborting (4..255)
// Ports
//   clk, rst     : clock, asynchronous active-low reset
//   req0/req1    : request levels
//   md0/mr0, md1/mr1 : operands per port
//   rsp_valid0/1 : one-cycle completion pulse to the owning port
//   err0/1       : one-cycle abort pulse, coincident with rsp_valid
//   res0/1       : last product delivered to each port (held)
//   mul_init     : one-cycle start to the multiplier
//   mul_md/mr    : latched operands to the multiplier
//   mul_done     : multiplier done level (may stay high until next init)
//   mul_pp       : multiplier product
//   busy         : high whenever the sequencer is not idle
//   owner        : port currently or last granted
//   dbg          : internal state (FSM, timeout counter, done_q, last_owner)
//
// Handshake: a port raises req and keeps its operands stable while req is
// high. There is no back-pressure on the response: rsp_valid is a single
// cycle pulse (with err on abort) and res holds the product afterwards.
// A req still high in the cycle after rsp_valid is a new request.
// -----------------------------------------------------------------------------
module mult_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [OP_W-1:0] md0,
  input  logic [OP_W-1:0] mr0,
  input  logic [OP_W-1:0] md1,
  input  logic [OP_W-1:0] mr1,
  output logic            rsp_valid0,
  output logic            rsp_valid1,
  output logic            err0,
  output logic            err1,
  output logic [PP_W-1:0] res0,
  output logic [PP_W-1:0] res1,
  output logic            mul_init,
  output logic [OP_W-1:0] mul_md,
  output logic [OP_W-1:0] mul_mr,
  input  logic            mul_done,
  input  logic [PP_W-1:0] mul_pp,
  output logic            busy,
  output logic            owner,
  output mult_dbg_t       dbg
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             last_owner;

  logic             grant_valid;
  logic             grant_id;
  logic             take_grant;
  logic             done_rise;
  logic             timed_out;
  logic             finish;

  rr_arbiter2 u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Only a fresh low-to-high transition counts; a done level left high by
  // the previous operation is already in done_q and is ignored.
  assign done_rise  = mul_done & ~done_q;
  assign timed_out  = (cnt == TIMEOUT_C);
  assign take_grant = (state == ST_IDLE) & grant_valid;
  // Completion wins over a timeout that lands on the same cycle.
  assign finish     = (state == ST_WAIT) & (done_rise | timed_out);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (grant_valid) state_nx = ST_ISSUE;
      ST_ISSUE:   state_nx = ST_WAIT;
      ST_WAIT:    if (done_rise || timed_out) state_nx = ST_DELIVER;
      ST_DELIVER: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Sequencer control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done_q     <= 1'b0;
      cnt        <= '0;
      mul_init   <= 1'b0;
      owner      <= PORT0;
      last_owner <= PORT1;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != ST_IDLE);
      done_q   <= mul_done;
      mul_init <= take_grant;

      if (take_grant) begin
        owner <= grant_id;
      end

      if (state == ST_ISSUE) begin
        cnt <= '0;
      end else if ((state == ST_WAIT) && !done_rise && !timed_out) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_DELIVER) begin
        last_owner <= owner;
      end
    end
  end

  // Operand latch: held from ISSUE until the next grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_md <= '0;
      mul_mr <= '0;
    end else if (take_grant) begin
      mul_md <= pick_op(grant_id, md0, md1);
      mul_mr <= pick_op(grant_id, mr0, mr1);
    end
  end

  // Response path: pulses are raised on entry to DELIVER so they appear in
  // the DELIVER cycle together with the updated result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      res0       <= '0;
      res1       <= '0;
    end else begin
      rsp_valid0 <= finish & (owner == PORT0);
      rsp_valid1 <= finish & (owner == PORT1);
      err0       <= finish & ~done_rise & (owner == PORT0);
      err1       <= finish & ~done_rise & (owner == PORT1);

      // An aborted transaction leaves the result untouched
      if (finish && done_rise) begin
        if (owner == PORT1) begin
          res1 <= mul_pp;
        end else begin
          res0 <= mul_pp;
        end
      end
    end
  end

  always_comb begin
    dbg.state      = state;
    dbg.cnt        = cnt;
    dbg.done_q     = done_q;
    dbg.last_owner = last_owner;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Bench for mult_arbiter: behavioural multiplier, transaction-level reference
// model with per-cycle output comparison, response scoreboard, directed
// scenarios with hand-computed expectations, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;
  import mult_ctrl_pkg::*;

  localparam int TO = 31;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------- DUT
  logic            req0, req1;
  logic [OP_W-1:0] md0, mr0, md1, mr1;
  logic            rsp_valid0, rsp_valid1, err0, err1;
  logic [PP_W-1:0] res0, res1;
  logic            mul_init;
  logic [OP_W-1:0] mul_md, mul_mr;
  logic            mul_done;
  logic [PP_W-1:0] mul_pp;
  logic            busy, owner;
  mult_dbg_t       dbg;

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .md0        (md0),
    .mr0        (mr0),
    .md1        (md1),
    .mr1        (mr1),
    .rsp_valid0 (rsp_valid0),
    .rsp_valid1 (rsp_valid1),
    .err0       (err0),
    .err1       (err1),
    .res0       (res0),
    .res1       (res1),
    .mul_init   (mul_init),
    .mul_md     (mul_md),
    .mul_mr     (mul_mr),
    .mul_done   (mul_done),
    .mul_pp     (mul_pp),
    .busy       (busy),
    .owner      (owner),
    .dbg        (dbg)
  );

  // ---------------------------------------------------------------- counters
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- multiplier model knobs
  int  lat_fixed = 8;   // 0 selects a random latency 2..12
  bit  hang_all  = 0;   // never raise done
  int  hang_pct  = 0;   // per-operation chance of hanging
  int  mm_cnt    = -1;
  bit  mm_clear  = 0;
  logic [7:0] mm_prod;

  // ---------------------------------------------------------------- reference model
  bit         t_active;
  bit         t_port;
  int         t_start;
  int         t_resp;
  bit         t_abort;
  logic [7:0] t_prod;
  bit         m_last;
  bit         m_owner;
  logic [3:0] m_md, m_mr;
  logic [7:0] m_res [2];
  bit         prev_done;

  // expectations for the current cycle
  logic       e_init, e_busy, e_owner, e_rv0, e_rv1, e_err0, e_err1;
  logic [3:0] e_md, e_mr;
  logic [7:0] e_res0, e_res1;
  logic [1:0] e_state;

  // response scoreboard: {err, port, result}
  logic [9:0] exp_q [$];

  // response log for directed checks
  int         lg_cyc  [$];
  logic       lg_port [$];
  logic       lg_err  [$];
  logic [7:0] lg_res  [$];

  task automatic model_reset();
    t_active  = 0;
    t_resp    = -1;
    m_last    = 1;
    m_owner   = 0;
    m_md      = '0;
    m_mr      = '0;
    m_res[0]  = '0;
    m_res[1]  = '0;
    prev_done = 0;
    exp_q.delete();
    mm_cnt    = -1;
    mm_clear  = 0;
    mul_done  = 0;
    mul_pp    = '0;
    e_init = 0; e_busy = 0; e_owner = 0; e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
    e_md = '0; e_mr = '0; e_res0 = '0; e_res1 = '0; e_state = ST_IDLE;
  endtask

  always @(negedge clk) begin
    if (!rst) model_reset();

    // compare this cycle's DUT outputs against the model
    check("mul_init", 16'(mul_init),   16'(e_init));
    check("mul_md",   16'(mul_md),     16'(e_md));
    check("mul_mr",   16'(mul_mr),     16'(e_mr));
    check("rsp_v0",   16'(rsp_valid0), 16'(e_rv0));
    check("rsp_v1",   16'(rsp_valid1), 16'(e_rv1));
    check("err0",     16'(err0),       16'(e_err0));
    check("err1",     16'(err1),       16'(e_err1));
    check("res0",     16'(res0),       16'(e_res0));
    check("res1",     16'(res1),       16'(e_res1));
    check("busy",     16'(busy),       16'(e_busy));
    check("owner",    16'(owner),      16'(e_owner));
    check("state",    16'(dbg.state),  16'(e_state));

    if (rst) begin
      // scoreboard + log of delivered responses
      if (rsp_valid0 || rsp_valid1) begin
        lg_cyc.push_back(cyc);
        lg_port.push_back(rsp_valid1);
        lg_err.push_back(rsp_valid1 ? err1 : err0);
        lg_res.push_back(rsp_valid1 ? res1 : res0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 16'(rsp_valid1), 16'hFFFF);
        end else begin
          check("rsp_sb", 16'({rsp_valid1 ? err1 : err0, rsp_valid1, rsp_valid1 ? res1 : res0}),
                16'(exp_q.pop_front()));
        end
      end

      // behavioural multiplier: done rises L cycles after init, stays high
      // until one cycle after the next init
      if (mul_init) begin
        mm_prod  = 8'(mul_md) * 8'(mul_mr);
        mm_cnt   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(12, 2));
        if (hang_all || int'($urandom_range(99, 0)) < hang_pct) mm_cnt = -1;
        mm_clear = 1;
      end else begin
        if (mm_clear) begin
          mul_done = 0;
          mm_clear = 0;
        end
        if (mm_cnt > 0) begin
          mm_cnt--;
          if (mm_cnt == 0) begin
            mul_done = 1;
            mul_pp   = mm_prod;
            mm_cnt   = -1;
          end
        end
      end
      if (!mul_done) mul_pp = 8'($urandom);

      // transaction-level reference: what this cycle means, then what the
      // outputs must be next cycle
      if (t_active && cyc == t_resp) begin
        t_active = 0;
        m_last   = t_port;
      end else if (!t_active) begin
        if (req0 || req1) begin
          t_port   = (req0 && req1) ? !m_last : req1;
          t_active = 1;
          t_start  = cyc;
          t_resp   = -1;
          m_owner  = t_port;
          m_md     = t_port ? md1 : md0;
          m_mr     = t_port ? mr1 : mr0;
        end
      end else if (t_resp < 0 && cyc >= t_start + 2) begin
        if (mul_done && !prev_done) begin
          t_resp  = cyc + 1;
          t_abort = 0;
          t_prod  = mul_pp;
          exp_q.push_back({1'b0, t_port, t_prod});
        end else if (cyc == t_start + 2 + TO) begin
          t_resp  = cyc + 1;
          t_abort = 1;
          exp_q.push_back({1'b1, t_port, m_res[t_port]});
        end
      end
      prev_done = mul_done;

      e_init  = t_active && (cyc + 1 == t_start + 1);
      e_busy  = t_active;
      e_rv0   = t_active && (t_resp == cyc + 1) && !t_port;
      e_rv1   = t_active && (t_resp == cyc + 1) && t_port;
      e_err0  = e_rv0 && t_abort;
      e_err1  = e_rv1 && t_abort;
      if (t_active && t_resp == cyc + 1 && !t_abort) m_res[t_port] = t_prod;
      e_res0  = m_res[0];
      e_res1  = m_res[1];
      e_owner = m_owner;
      e_md    = m_md;
      e_mr    = m_mr;
      if (!t_active)                   e_state = ST_IDLE;
      else if (cyc + 1 == t_start + 1) e_state = ST_ISSUE;
      else if (cyc + 1 == t_resp)      e_state = ST_DELIVER;
      else                             e_state = ST_WAIT;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  int t;
  int base;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    step(2);
    rst = 1;
    step(1);
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (lg_cyc.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (lg_cyc.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d responses after %0d cycles, want %0d", name, lg_cyc.size(), budget, n);
    end
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    int quiet = 0;
    while (quiet < 2 && k < budget) begin
      step(1);
      k++;
      quiet = t_active ? 0 : quiet + 1;
    end
    if (quiet < 2) begin
      checks++;
      errors++;
      $display("FAIL quiet: still active after %0d cycles", budget);
    end
  endtask

  task automatic log_check(input int idx, input logic port, input logic err,
                           input logic [7:0] res, input string name);
    if (idx >= lg_cyc.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: response %0d missing", name, idx);
    end else begin
      check({name, "_port"}, 16'(lg_port[idx]), 16'(port));
      check({name, "_err"},  16'(lg_err[idx]),  16'(err));
      check({name, "_res"},  16'(lg_res[idx]),  16'(res));
    end
  endtask

  task automatic lat_check(input int idx, input int from, input int want, input string name);
    if (idx >= lg_cyc.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: response %0d missing", name, idx);
    end else begin
      check(name, 16'(lg_cyc[idx] - from), 16'(want));
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 0;
    req0 = 0; req1 = 0;
    md0 = '0; mr0 = '0; md1 = '0; mr1 = '0;
    mul_done = 0; mul_pp = '0;
    step(3);
    rst = 1;
    step(2);

    // single request: 3 x 5, done 8 cycles after init
    base = lg_cyc.size();
    md0 = 4'd3; mr0 = 4'd5; req0 = 1; t = cyc;
    step(1);
    req0 = 0;
    wait_log(base + 1, 60, "single");
    log_check(base, 1'b0, 1'b0, 8'h0F, "single");
    lat_check(base, t, 10, "single_lat");
    wait_quiet(60);

    // tie after reset, then held requests alternate; done stays stale-high
    do_reset();
    base = lg_cyc.size();
    md0 = 4'd2; mr0 = 4'd7; md1 = 4'd4; mr1 = 4'd4;
    req0 = 1; req1 = 1; t = cyc;
    wait_log(base + 4, 200, "tie");
    req0 = 0; req1 = 0;
    log_check(base,     1'b0, 1'b0, 8'd14, "tie0");
    log_check(base + 1, 1'b1, 1'b0, 8'd16, "tie1");
    log_check(base + 2, 1'b0, 1'b0, 8'd14, "tie2");
    log_check(base + 3, 1'b1, 1'b0, 8'd16, "tie3");
    lat_check(base, t, 10, "tie_lat");
    if (lg_cyc.size() > base) lat_check(base + 1, lg_cyc[base], 11, "stale_lat");
    wait_quiet(60);

    // timeout on port 1: multiplier never answers
    hang_all = 1;
    base = lg_cyc.size();
    md1 = 4'd9; mr1 = 4'd9; req1 = 1; t = cyc;
    step(1);
    req1 = 0;
    wait_log(base + 1, 60, "timeout");
    log_check(base, 1'b1, 1'b1, 8'd16, "timeout");
    lat_check(base, t, 34, "timeout_lat");
    hang_all = 0;
    wait_quiet(60);

    // normal service after the abort
    base = lg_cyc.size();
    md0 = 4'd6; mr0 = 4'd7; req0 = 1;
    step(1);
    req0 = 0;
    wait_log(base + 1, 60, "post_to");
    log_check(base, 1'b0, 1'b0, 8'd42, "post_to");
    wait_quiet(60);

    // reset in the middle of WAIT
    base = lg_cyc.size();
    md0 = 4'd5; mr0 = 4'd5; req0 = 1;
    step(1);
    req0 = 0;
    step(3);
    rst = 0;
    #1;
    check("arst_busy",  16'(busy),       16'h0);
    check("arst_md",    16'(mul_md),     16'h0);
    check("arst_mr",    16'(mul_mr),     16'h0);
    check("arst_res0",  16'(res0),       16'h0);
    check("arst_res1",  16'(res1),       16'h0);
    check("arst_owner", 16'(owner),      16'h0);
    check("arst_state", 16'(dbg.state),  16'(ST_IDLE));
    req0 = 1; req1 = 1;
    step(2);
    check("arst_norsp", 16'(lg_cyc.size()), 16'(base));
    rst = 1;
    step(1);
    req0 = 0;
    wait_log(base + 2, 80, "arst_tie");
    req1 = 0;
    log_check(base,     1'b0, 1'b0, 8'd25, "arst_tie0");
    log_check(base + 1, 1'b1, 1'b0, 8'd81, "arst_tie1");
    wait_quiet(60);

    // request dropped while waiting: still delivered, no restart
    base = lg_cyc.size();
    md0 = 4'd3; mr0 = 4'd3; req0 = 1;
    step(3);
    req0 = 0;
    wait_log(base + 1, 60, "drop");
    log_check(base, 1'b0, 1'b0, 8'd9, "drop");
    step(20);
    check("drop_norestart", 16'(lg_cyc.size()), 16'(base + 1));

    // randomized traffic
    lat_fixed = 0;
    hang_pct  = 5;
    for (int i = 0; i < 2000; i++) begin
      if (!req0) begin
        if ($urandom_range(3, 0) == 0) begin
          md0 = 4'($urandom); mr0 = 4'($urandom); req0 = 1;
        end
      end else if ($urandom_range(15, 0) == 0) begin
        req0 = 0;
      end
      if (!req1) begin
        if ($urandom_range(3, 0) == 0) begin
          md1 = 4'($urandom); mr1 = 4'($urandom); req1 = 1;
        end
      end else if ($urandom_range(15, 0) == 0) begin
        req1 = 0;
      end
      step(1);
    end
    req0 = 0;
    req1 = 0;
    wait_quiet(100);
    check("sb_drained", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
